// File: rtl/class_bbox_accum.sv
// -----------------------------------------------------------------------------
// class_bbox_accum
//   Collects, over one frame of the pixel classifier's 3-bit class stream, a
//   bounding box (x/y min/max) and a saturating pixel count for every
//   non-background class.  After the last pixel of the frame it plays out one
//   record per class (1..NUM_CLASSES-1) over a valid/ready handshake, holding
//   off the classifier (in_ready=0) until the last record is taken.
//
// Ports
//   clk, rst            single rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   pixel handshake; transfer = in_valid & in_ready
//   in_sop/eol/eop      first pixel of frame / last of line / last of frame
//   pixel_class         class code of the current pixel (0 = background)
//   out_valid/out_ready record handshake
//   out_class           class index of the record
//   out_found           class had at least one counted pixel
//   out_xmin..out_ymax  bounding box, zero when !out_found
//   out_count           counted pixels, saturating at all-ones
//   frame_done          one-cycle pulse after the last record is accepted
//
// Configuration
//   BBOX_RUN_FILTER_EN  when defined, a pixel only counts if the previous
//                       accepted pixel on the same line had the same class;
//                       pixels at x=0 never count.
// -----------------------------------------------------------------------------
module class_bbox_accum #(
  parameter int IMAGE_W     = 640,
  parameter int IMAGE_H     = 480,
  parameter int X_W         = 11,
  parameter int Y_W         = 11,
  parameter int NUM_CLASSES = 8,
  parameter int CNT_W       = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sop,
  input  logic             in_eol,
  input  logic             in_eop,
  input  logic [2:0]       pixel_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_class,
  output logic             out_found,
  output logic [X_W-1:0]   out_xmin,
  output logic [X_W-1:0]   out_xmax,
  output logic [Y_W-1:0]   out_ymin,
  output logic [Y_W-1:0]   out_ymax,
  output logic [CNT_W-1:0] out_count,
  output logic             frame_done
);

  localparam logic [X_W-1:0]   X_LAST   = X_W'(IMAGE_W - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(IMAGE_H - 1);
  localparam logic [X_W-1:0]   X_ONE    = {{(X_W-1){1'b0}}, 1'b1};
  localparam logic [Y_W-1:0]   Y_ONE    = {{(Y_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       LAST_CLS = 3'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_READOUT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [X_W-1:0]     xmin_q [NUM_CLASSES];
  logic [X_W-1:0]     xmin_d [NUM_CLASSES];
  logic [X_W-1:0]     xmax_q [NUM_CLASSES];
  logic [X_W-1:0]     xmax_d [NUM_CLASSES];
  logic [Y_W-1:0]     ymin_q [NUM_CLASSES];
  logic [Y_W-1:0]     ymin_d [NUM_CLASSES];
  logic [Y_W-1:0]     ymax_q [NUM_CLASSES];
  logic [Y_W-1:0]     ymax_d [NUM_CLASSES];
  logic [CNT_W-1:0]   cnt_q  [NUM_CLASSES];
  logic [CNT_W-1:0]   cnt_d  [NUM_CLASSES];
  logic [2:0]         rd_idx_q, rd_idx_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [2:0]         out_class_q, out_class_d;
  logic               out_found_q, out_found_d;
  logic [X_W-1:0]     out_xmin_q, out_xmin_d, out_xmax_q, out_xmax_d;
  logic [Y_W-1:0]     out_ymin_q, out_ymin_d, out_ymax_q, out_ymax_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
`ifdef BBOX_RUN_FILTER_EN
  logic [2:0]         prev_q, prev_d;
`endif

  logic               fire_s, start_s, proc_s, class_ok_s, run_ok_s, hit_s, load_s;
  logic [X_W-1:0]     cur_x_s;
  logic [Y_W-1:0]     cur_y_s;

  // in_ready is low exactly in READOUT, so a transfer never happens there.
  assign fire_s     = in_valid & in_ready_q;
  assign start_s    = fire_s & in_sop;
  assign proc_s     = fire_s & (in_sop | (state_q == S_ACCUM));
  // A start-of-frame pixel is located at (0,0) regardless of the counters.
  assign cur_x_s    = in_sop ? '0 : x_q;
  assign cur_y_s    = in_sop ? '0 : y_q;
  assign class_ok_s = (pixel_class != 3'd0) && (int'(pixel_class) < NUM_CLASSES);
`ifdef BBOX_RUN_FILTER_EN
  assign run_ok_s   = (cur_x_s != '0) && (pixel_class == prev_q);
`else
  assign run_ok_s   = 1'b1;
`endif
  assign hit_s      = proc_s & class_ok_s & run_ok_s;

  // Next-state: accumulators, coordinates, FSM and the record register.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    xmin_d       = xmin_q;
    xmax_d       = xmax_q;
    ymin_d       = ymin_q;
    ymax_d       = ymax_q;
    cnt_d        = cnt_q;
    rd_idx_d     = rd_idx_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;
    out_class_d  = out_class_q;
    out_found_d  = out_found_q;
    out_xmin_d   = out_xmin_q;
    out_xmax_d   = out_xmax_q;
    out_ymin_d   = out_ymin_q;
    out_ymax_d   = out_ymax_q;
    out_count_d  = out_count_q;
    load_s       = 1'b0;
`ifdef BBOX_RUN_FILTER_EN
    prev_d       = prev_q;
`endif

    // Clear first so the sop pixel itself lands in freshly reset boxes.
    if (start_s) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        xmin_d[i] = '1;
        xmax_d[i] = '0;
        ymin_d[i] = '1;
        ymax_d[i] = '0;
        cnt_d[i]  = '0;
      end
    end else begin
      cnt_d = cnt_d;
    end

    if (hit_s) begin
      if (cur_x_s < xmin_d[pixel_class]) xmin_d[pixel_class] = cur_x_s;
      else                               xmin_d[pixel_class] = xmin_d[pixel_class];
      if (cur_x_s > xmax_d[pixel_class]) xmax_d[pixel_class] = cur_x_s;
      else                               xmax_d[pixel_class] = xmax_d[pixel_class];
      if (cur_y_s < ymin_d[pixel_class]) ymin_d[pixel_class] = cur_y_s;
      else                               ymin_d[pixel_class] = ymin_d[pixel_class];
      if (cur_y_s > ymax_d[pixel_class]) ymax_d[pixel_class] = cur_y_s;
      else                               ymax_d[pixel_class] = ymax_d[pixel_class];
      if (cnt_d[pixel_class] != '1)      cnt_d[pixel_class]  = cnt_d[pixel_class] + CNT_ONE;
      else                               cnt_d[pixel_class]  = cnt_d[pixel_class];
    end else begin
      cnt_d = cnt_d;
    end

    // Coordinates saturate at the last column/line instead of wrapping.
    if (proc_s) begin
      if (in_eol) begin
        x_d = '0;
        y_d = (cur_y_s == Y_LAST) ? cur_y_s : cur_y_s + Y_ONE;
      end else begin
        x_d = (cur_x_s == X_LAST) ? cur_x_s : cur_x_s + X_ONE;
        y_d = cur_y_s;
      end
`ifdef BBOX_RUN_FILTER_EN
      prev_d = in_eol ? 3'd0 : pixel_class;
`endif
    end else begin
      x_d = x_q;
    end

    if (proc_s && in_eop) begin
      state_d     = S_READOUT;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b1;
      rd_idx_d    = 3'd1;
      load_s      = 1'b1;
    end else if (start_s) begin
      state_d = S_ACCUM;
    end else if ((state_q == S_READOUT) && out_ready) begin
      if (rd_idx_q == LAST_CLS) begin
        state_d      = S_IDLE;
        in_ready_d   = 1'b1;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b1;
        out_class_d  = 3'd0;
        out_found_d  = 1'b0;
        out_xmin_d   = '0;
        out_xmax_d   = '0;
        out_ymin_d   = '0;
        out_ymax_d   = '0;
        out_count_d  = '0;
      end else begin
        rd_idx_d = rd_idx_q + 3'd1;
        load_s   = 1'b1;
      end
    end else begin
      state_d = state_q;
    end

    // Records read the post-update accumulators so the eop pixel is included.
    if (load_s) begin
      out_class_d = rd_idx_d;
      out_found_d = (cnt_d[rd_idx_d] != '0);
      out_xmin_d  = out_found_d ? xmin_d[rd_idx_d] : '0;
      out_xmax_d  = out_found_d ? xmax_d[rd_idx_d] : '0;
      out_ymin_d  = out_found_d ? ymin_d[rd_idx_d] : '0;
      out_ymax_d  = out_found_d ? ymax_d[rd_idx_d] : '0;
      out_count_d = cnt_d[rd_idx_d];
    end else begin
      out_class_d = out_class_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        xmin_q[i] <= '1;
        xmax_q[i] <= '0;
        ymin_q[i] <= '1;
        ymax_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rd_idx_q     <= 3'd0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_class_q  <= 3'd0;
      out_found_q  <= 1'b0;
      out_xmin_q   <= '0;
      out_xmax_q   <= '0;
      out_ymin_q   <= '0;
      out_ymax_q   <= '0;
      out_count_q  <= '0;
`ifdef BBOX_RUN_FILTER_EN
      prev_q       <= 3'd0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      cnt_q        <= cnt_d;
      rd_idx_q     <= rd_idx_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      out_class_q  <= out_class_d;
      out_found_q  <= out_found_d;
      out_xmin_q   <= out_xmin_d;
      out_xmax_q   <= out_xmax_d;
      out_ymin_q   <= out_ymin_d;
      out_ymax_q   <= out_ymax_d;
      out_count_q  <= out_count_d;
`ifdef BBOX_RUN_FILTER_EN
      prev_q       <= prev_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign out_class  = out_class_q;
  assign out_found  = out_found_q;
  assign out_xmin   = out_xmin_q;
  assign out_xmax   = out_xmax_q;
  assign out_ymin   = out_ymin_q;
  assign out_ymax   = out_ymax_q;
  assign out_count  = out_count_q;

endmodule

// File: tb/tb_class_bbox_accum.sv
// Bench for class_bbox_accum: directed frames plus randomized frames, checked
// every cycle against a frame-level model that keeps the list of counted
// pixels and derives each class's box/count by scanning it at end of frame.
module tb_class_bbox_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sop, in_eol, in_eop;
  logic [2:0]  pixel_class;
  logic        out_valid, out_ready, out_found, frame_done;
  logic [2:0]  out_class;
  logic [10:0] out_xmin, out_xmax, out_ymin, out_ymax;
  logic [19:0] out_count;

  class_bbox_accum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sop(in_sop), .in_eol(in_eol), .in_eop(in_eop), .pixel_class(pixel_class),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_found(out_found), .out_xmin(out_xmin), .out_xmax(out_xmax),
    .out_ymin(out_ymin), .out_ymax(out_ymax), .out_count(out_count),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  cls;
    logic        found;
    logic [10:0] xmin, xmax, ymin, ymax;
    logic [19:0] cnt;
  } rec_t;

  int   errors = 0;
  int   checks = 0;
  rec_t expq[$];
  rec_t last_rec [8];
  int   px_x[$], px_y[$], px_c[$];
  int   mx, my, mprev;
  bit   m_active, shown, fd_exp;
  int   rdy_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // End-of-frame: scan the counted pixels once per class.
  task automatic build_records();
    rec_t r;
    for (int c = 1; c < 8; c++) begin
      r = '0;
      r.cls = 3'(c);
      for (int k = 0; k < px_c.size(); k++) begin
        if (px_c[k] == c) begin
          if (!r.found) begin
            r.found = 1'b1;
            r.xmin = 11'(px_x[k]); r.xmax = 11'(px_x[k]);
            r.ymin = 11'(px_y[k]); r.ymax = 11'(px_y[k]);
          end else begin
            if (px_x[k] < r.xmin) r.xmin = 11'(px_x[k]);
            if (px_x[k] > r.xmax) r.xmax = 11'(px_x[k]);
            if (px_y[k] < r.ymin) r.ymin = 11'(px_y[k]);
            if (px_y[k] > r.ymax) r.ymax = 11'(px_y[k]);
          end
          if (r.cnt != 20'hFFFFF) r.cnt = r.cnt + 20'd1;
        end
      end
      last_rec[c] = r;
      expq.push_back(r);
    end
  endtask

  task automatic model_accept(input int c, input bit s, input bit e, input bit p);
    int cx, cy;
    bit ok;
    if (!(m_active || s)) return;
    if (s) begin
      px_x.delete(); px_y.delete(); px_c.delete();
      cx = 0; cy = 0;
    end else begin
      cx = mx; cy = my;
    end
    ok = (c != 0);
`ifdef BBOX_RUN_FILTER_EN
    ok = ok && (cx != 0) && (mprev == c);
`endif
    if (ok) begin
      px_x.push_back(cx); px_y.push_back(cy); px_c.push_back(c);
    end
    mprev = e ? 0 : c;
    if (e) begin
      mx = 0;
      my = (cy == 479) ? 479 : cy + 1;
    end else begin
      mx = (cx == 639) ? 639 : cx + 1;
      my = cy;
    end
    if (p) begin
      build_records();
      m_active = 1'b0;
    end else if (s) begin
      m_active = 1'b1;
    end
  endtask

  task automatic model_clear();
    expq.delete(); px_x.delete(); px_y.delete(); px_c.delete();
    shown = 1'b0; m_active = 1'b0; mx = 0; my = 0; mprev = 0;
  endtask

  // Per-cycle compare, sampled 1 time unit after the rising edge.
  always begin
    rec_t hd;
    @(posedge clk);
    if (shown && out_ready) begin
      hd = expq.pop_front();
      fd_exp = (expq.size() == 0);
    end else begin
      fd_exp = 1'b0;
    end
    shown = (expq.size() != 0);
    #1;
    chk("out_valid", 32'(out_valid), 32'(shown));
    chk("in_ready", 32'(in_ready), 32'(!shown));
    chk("frame_done", 32'(frame_done), 32'(fd_exp));
    if (shown) begin
      hd = expq[0];
      chk("rec_class", 32'(out_class), 32'(hd.cls));
      chk("rec_found", 32'(out_found), 32'(hd.found));
      chk("rec_xmin", 32'(out_xmin), 32'(hd.xmin));
      chk("rec_xmax", 32'(out_xmax), 32'(hd.xmax));
      chk("rec_ymin", 32'(out_ymin), 32'(hd.ymin));
      chk("rec_ymax", 32'(out_ymax), 32'(hd.ymax));
      chk("rec_count", 32'(out_count), 32'(hd.cnt));
    end
  end

  // Consumer back-pressure: 0 = always ready, 1 = stalled, else random.
  always @(negedge clk) begin
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'b0;
    else                    out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input int c, input bit s, input bit e, input bit p, input int gap);
    int b;
    b = 0;
    pixel_class = 3'(c); in_sop = s; in_eol = e; in_eop = p; in_valid = 1'b1;
    while (!in_ready && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout: in_ready stuck at %0d, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    model_accept(c, s, e, p);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((expq.size() != 0 || shown) && b < 300) begin
      @(negedge clk);
      b++;
    end
    checks++;
    if (expq.size() != 0 || shown) begin
      errors++;
      $display("FAIL drain_timeout: %0d records left, required 0", expq.size());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_frame();
    int w, h, ab;
    w = $urandom_range(1, 6);
    h = $urandom_range(1, 4);
    if ($urandom_range(0, 2) == 0) send($urandom_range(0, 7), 0, 0, $urandom_range(0, 1), 0);
    if ($urandom_range(0, 3) == 0) begin
      ab = $urandom_range(1, 5);
      for (int i = 0; i < ab; i++) send($urandom_range(0, 7), i == 0, 0, 0, 0);
    end
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        send($urandom_range(0, 7), (x == 0 && y == 0), (x == w - 1),
             (x == w - 1 && y == h - 1), $urandom_range(0, 3) == 0 ? 1 : 0);
    wait_drain();
  endtask

  initial begin
    int pulses, at;
    rst = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eol = 1'b0; in_eop = 1'b0;
    pixel_class = 3'd0; rdy_mode = 0; out_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 4x2 frame with class 2 at (1,0) and (2,1).
    send(0, 1, 0, 0, 0); send(2, 0, 0, 0, 0); send(0, 0, 0, 0, 0); send(0, 0, 1, 0, 0);
    send(0, 0, 0, 0, 0); send(0, 0, 0, 0, 0); send(2, 0, 0, 0, 0); send(0, 0, 1, 1, 0);
    chk("t2_c2_found", 32'(last_rec[2].found), 32'd1);
    chk("t2_c2_xmin", 32'(last_rec[2].xmin), 32'd1);
    chk("t2_c2_xmax", 32'(last_rec[2].xmax), 32'd2);
    chk("t2_c2_ymin", 32'(last_rec[2].ymin), 32'd0);
    chk("t2_c2_ymax", 32'(last_rec[2].ymax), 32'd1);
    chk("t2_c2_count", 32'(last_rec[2].cnt), 32'd2);
    chk("t2_c1_found", 32'(last_rec[1].found), 32'd0);
    chk("t2_c3_xmin", 32'(last_rec[3].xmin), 32'd0);
    wait_drain();

    // Stalled consumer, then seven records in seven cycles.
    rdy_mode = 1;
    send(3, 1, 1, 1, 0);
    chk("t3_c3_count", 32'(last_rec[3].cnt), 32'd1);
    repeat (5) @(negedge clk);
    chk("t3_hold_valid", 32'(out_valid), 32'd1);
    chk("t3_hold_class", 32'(out_class), 32'd1);
    chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
    rdy_mode = 0; out_ready = 1'b1;
    pulses = 0; at = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (frame_done) begin
        pulses++;
        at = i;
      end
    end
    chk("t3_done_pulses", 32'(pulses), 32'd1);
    chk("t3_done_cycle", 32'(at), 32'd7);
    wait_drain();

    // Restart with sop at (3,1): only post-restart pixels count.
    for (int x = 0; x < 6; x++) send(1, x == 0, x == 5, 0, 0);
    send(5, 0, 0, 0, 0); send(5, 0, 0, 0, 0); send(5, 0, 0, 0, 0);
    send(4, 1, 0, 0, 0); send(0, 0, 0, 0, 0); send(4, 0, 1, 0, 0);
    send(0, 0, 0, 0, 0); send(4, 0, 1, 1, 0);
    chk("t4_c1_found", 32'(last_rec[1].found), 32'd0);
    chk("t4_c5_found", 32'(last_rec[5].found), 32'd0);
    chk("t4_c4_xmax", 32'(last_rec[4].xmax), 32'd2);
    chk("t4_c4_ymax", 32'(last_rec[4].ymax), 32'd1);
    chk("t4_c4_count", 32'(last_rec[4].cnt), 32'd3);
    wait_drain();

    // 700 pixels on one line: x saturates at 639.
    for (int i = 0; i < 700; i++) send(7, i == 0, 0, i == 699, 0);
    chk("t5_c7_xmax", 32'(last_rec[7].xmax), 32'd639);
    chk("t5_c7_count", 32'(last_rec[7].cnt), 32'd700);
    wait_drain();
    for (int i = 0; i < 6; i++) send(0, i == 0, i == 2 || i == 5, i == 5, 0);
    for (int c = 1; c < 8; c++) chk("t5_bg_found", 32'(last_rec[c].found), 32'd0);
    wait_drain();

    // Run line "0 3 3 0 3".
    send(0, 1, 0, 0, 0); send(3, 0, 0, 0, 0); send(3, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0); send(3, 0, 1, 1, 0);
`ifdef BBOX_RUN_FILTER_EN
    chk("t6_c3_count", 32'(last_rec[3].cnt), 32'd1);
    chk("t6_c3_xmin", 32'(last_rec[3].xmin), 32'd2);
    chk("t6_c3_xmax", 32'(last_rec[3].xmax), 32'd2);
`else
    chk("t6_c3_count", 32'(last_rec[3].cnt), 32'd3);
    chk("t6_c3_xmin", 32'(last_rec[3].xmin), 32'd1);
    chk("t6_c3_xmax", 32'(last_rec[3].xmax), 32'd4);
`endif
    wait_drain();

    // Reset during readout, then during accumulation.
    rdy_mode = 1;
    send(6, 1, 0, 0, 0); send(6, 0, 1, 1, 0);
    repeat (2) @(negedge clk);
    do_reset();
    rdy_mode = 0;
    send(2, 1, 0, 0, 0); send(2, 0, 0, 0, 0);
    do_reset();
    send(1, 0, 0, 0, 0);
    send(5, 1, 1, 0, 0); send(5, 0, 0, 1, 0);
    wait_drain();

    // Randomized frames with random back-pressure.
    rdy_mode = 2;
    for (int f = 0; f < 30; f++) rand_frame();
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
